usb_rx_data_buffer: RTL and testbench
=====================================

USB_RX_DATA_BUFFER -- requirements
Module: usb_rx_data_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, buffer capacity in bytes (one full-speed bulk max packet).
REQ-002 SHALL have parameter AW, default 6, address width; log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fill_dbuff  input  1  write strobe from receive controller; one byte per high cycle.
REQ-006 SHALL have port data  input  8  received byte, sampled when fill_dbuff=1.
REQ-007 SHALL have port pckt_commit  input  1  single-cycle pulse; current packet CRC good, make its bytes readable.
REQ-008 SHALL have port pckt_discard  input  1  single-cycle pulse; current packet bad, drop its uncommitted bytes.
REQ-009 SHALL have port dbuff_clr  input  1  synchronous flush of the entire buffer.
REQ-010 SHALL have port read_en  input  1  pop request from SD side.
REQ-011 SHALL have port rd_data  output  8  popped byte, registered.
REQ-012 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-013 SHALL have port fifo_empty  output  1  no committed bytes available.
REQ-014 SHALL have port fifo_full  output  1  no free space, committed plus pending bytes = DEPTH.
REQ-015 SHALL have port byte_count  output  AW+1  committed bytes available, 0..DEPTH.
REQ-016 SHALL have port pend  output  1  uncommitted bytes held for the current packet.
REQ-017 SHALL have port overflow  output  1  sticky; a write was dropped because the buffer was full.

Function
REQ-018 SHALL store bytes in a DEPTH x 8 array with three AW+1-bit pointers: wr_ptr (tentative), cmt_ptr (committed), rd_ptr; the MSB acts as wrap bit, and all pointer arithmetic is modulo 2^(AW+1).
REQ-019 SHALL derive fifo_empty = (cmt_ptr == rd_ptr), fifo_full = (wr_ptr - rd_ptr == DEPTH), byte_count = cmt_ptr - rd_ptr, and pend = (wr_ptr != cmt_ptr), all combinationally from registered pointers.
REQ-020 On fill_dbuff=1 with fifo_full=0, SHALL write data to mem[wr_ptr] and increment wr_ptr.
REQ-021 On fill_dbuff=1 with fifo_full=1, SHALL drop the byte, hold wr_ptr, and set overflow and enter state OVF.
REQ-022 On read_en=1 with fifo_empty=0, SHALL load rd_data from mem[rd_ptr], increment rd_ptr, and assert rd_valid in the next cycle for exactly one cycle per pop; data latency is 1 cycle.
REQ-023 On read_en=1 with fifo_empty=1, SHALL ignore the request: rd_valid=0 next cycle, rd_data held.
REQ-024 Bytes SHALL become readable only after commit; uncommitted bytes SHALL never be popped.
REQ-025 SHALL implement packet FSM states IDLE (pend=0), PEND (pend=1), and OVF (a drop occurred in the current packet).
REQ-026 FSM transitions SHALL be: IDLE->PEND on an accepted write; PEND->IDLE on commit or discard; IDLE/PEND->OVF on a dropped write; OVF->IDLE on commit or discard.
REQ-027 pckt_commit in IDLE or PEND SHALL set cmt_ptr to wr_ptr, counting any byte accepted in the same cycle.
REQ-028 pckt_commit in OVF SHALL act as a discard, because a truncated packet is never released.
REQ-029 pckt_discard SHALL set wr_ptr to cmt_ptr; a write in the same cycle SHALL be ignored.
REQ-030 When pckt_commit and pckt_discard are both asserted, discard SHALL take precedence.
REQ-031 Simultaneous write and read SHALL both proceed; fifo_full is evaluated before the pop, so a write while full is dropped even if a pop occurs in the same cycle.
REQ-032 dbuff_clr SHALL zero all pointers, rd_valid and overflow, force IDLE, and take priority over all other inputs in the same cycle; memory contents need not be cleared.
REQ-033 overflow SHALL remain set until dbuff_clr or reset; commit and discard SHALL leave it unchanged.

Reset
REQ-034 On n_rst=0, SHALL asynchronously zero all pointers, set rd_data=8'h00, rd_valid=0, overflow=0, and state=IDLE, so outputs read fifo_empty=1, fifo_full=0, byte_count=0, pend=0.
REQ-035 Reset asserted mid-packet or mid-read SHALL discard all contents, with no partial output afterwards.

Verification
REQ-036 Write 8'hA1,8'hB2,8'hC3, then commit, then 3 pops -> rd_data A1,B2,C3 each one cycle after read_en with rd_valid=1, then fifo_empty=1.
REQ-037 Write 4 bytes without commit, then read_en -> rd_valid=0 and pend=1; then discard -> pend=0, byte_count=0.
REQ-038 Write 64 bytes then a 65th of 8'hFF -> fifo_full=1 and overflow=1; commit -> byte_count=0 and state IDLE.
REQ-039 Commit 60 bytes, pop 60, then write/commit 10 more -> pointers wrap and 10 bytes read back in order, byte_count 10->0.
REQ-040 Assert commit and discard together with 5 pending bytes -> bytes dropped, byte_count unchanged.
REQ-041 Pulse dbuff_clr with committed data and an overflow flag set, and separately assert n_rst mid-write -> all outputs at reset values in the next cycle, or immediately for n_rst.

Source files
------------

// File: rtl/usb_rx_data_buffer.sv
// USB receive data buffer: byte FIFO with packet-level commit/discard.
// Bytes are written tentatively at wr_ptr and only become poppable once
// the receive controller commits the packet (cmt_ptr catches up to wr_ptr).
module usb_rx_data_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          fill_dbuff,
  input  logic [7:0]    data,
  input  logic          pckt_commit,
  input  logic          pckt_discard,
  input  logic          dbuff_clr,
  input  logic          read_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   byte_count,
  output logic          pend,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, PEND, OVF} state_t;

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t      state, state_nxt;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, cmt_ptr, rd_ptr;
  logic [AW:0] wr_adv;
  logic        wr_ok, drop, trunc, disc, cmt, rd_ok;

  // Status flags straight from the registered pointers (MSB is the wrap bit).
  assign fifo_empty = (cmt_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == FULL_CNT);
  assign byte_count = cmt_ptr - rd_ptr;
  assign pend       = (wr_ptr != cmt_ptr);

  // A write that meets a full buffer truncates the packet; a commit of a
  // truncated packet (earlier drop, or a drop this very cycle) becomes a
  // discard so a partial packet never reaches the reader.
  assign drop   = fill_dbuff & fifo_full & ~pckt_discard;
  assign trunc  = (state == OVF) | drop;
  assign disc   = pckt_discard | (pckt_commit & trunc);
  assign cmt    = pckt_commit & ~disc;
  assign wr_ok  = fill_dbuff & ~fifo_full & ~disc;
  assign rd_ok  = read_en & ~fifo_empty;
  assign wr_adv = wr_ok ? wr_ptr + PTR_ONE : wr_ptr;

  // Packet FSM next state; end-of-packet wins over a drop in the same cycle.
  always_comb begin
    state_nxt = state;
    if (disc || cmt)                 state_nxt = IDLE;
    else if (drop)                   state_nxt = OVF;
    else if (wr_ok && state == IDLE) state_nxt = PEND;
  end

  // Packet FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         state <= IDLE;
    else if (dbuff_clr) state <= IDLE;
    else                state <= state_nxt;
  end

  // Pointers, sticky overflow flag and registered read port.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else if (dbuff_clr) begin
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      wr_ptr   <= disc ? cmt_ptr : wr_adv;
      cmt_ptr  <= cmt ? wr_adv : cmt_ptr;
      overflow <= overflow | drop;
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_ok && !dbuff_clr) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Bench for usb_rx_data_buffer: directed table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_usb_rx_data_buffer;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          fill_dbuff = 1'b0, pckt_commit = 1'b0, pckt_discard = 1'b0;
  logic          dbuff_clr = 1'b0, read_en = 1'b0;
  logic [7:0]    data = 8'h00;
  logic [7:0]    rd_data;
  logic          rd_valid, fifo_empty, fifo_full, pend, overflow;
  logic [AW:0]   byte_count;

  int checks = 0;
  int errors = 0;

  // Reference model: committed and pending bytes as plain queues.
  logic [7:0] q_cmt[$];
  logic [7:0] q_pnd[$];
  logic       m_ovf = 1'b0, m_trunc = 1'b0, m_rv = 1'b0;
  logic [7:0] m_rd = 8'h00;

  usb_rx_data_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .n_rst(n_rst), .fill_dbuff(fill_dbuff), .data(data),
    .pckt_commit(pckt_commit), .pckt_discard(pckt_discard),
    .dbuff_clr(dbuff_clr), .read_en(read_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .byte_count(byte_count), .pend(pend), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_cmt.delete(); q_pnd.delete();
    m_ovf = 0; m_trunc = 0; m_rv = 0; m_rd = 8'h00;
  endtask

  task automatic check_model();
    chk("rd_valid", int'(rd_valid), int'(m_rv));
    chk("rd_data", int'(rd_data), int'(m_rd));
    chk("fifo_empty", int'(fifo_empty), int'(q_cmt.size() == 0));
    chk("fifo_full", int'(fifo_full), int'(q_cmt.size() + q_pnd.size() == DEPTH));
    chk("byte_count", int'(byte_count), q_cmt.size());
    chk("pend", int'(pend), int'(q_pnd.size() != 0));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after.
  task automatic step(input logic f, input logic [7:0] d, input logic c,
                      input logic ds, input logic cl, input logic r);
    logic full, drop, disc;
    fill_dbuff = f; data = d; pckt_commit = c; pckt_discard = ds;
    dbuff_clr = cl; read_en = r;
    @(posedge clk);
    full = (q_cmt.size() + q_pnd.size() == DEPTH);
    if (cl) begin
      model_reset();
    end else begin
      if (r && q_cmt.size() > 0) begin m_rd = q_cmt.pop_front(); m_rv = 1; end
      else m_rv = 0;
      drop = f && full && !ds;
      if (drop) m_ovf = 1;
      disc = ds || (c && (m_trunc || drop));
      if (disc) begin
        q_pnd.delete(); m_trunc = 0;
      end else begin
        if (f && !full) q_pnd.push_back(d);
        if (drop) m_trunc = 1;
        if (c) begin
          foreach (q_pnd[i]) q_cmt.push_back(q_pnd[i]);
          q_pnd.delete(); m_trunc = 0;
        end
      end
    end
    #1;
    check_model();
  endtask

  task automatic idle();  step(0, 8'h00, 0, 0, 0, 0); endtask
  task automatic wr(input logic [7:0] d); step(1, d, 0, 0, 0, 0); endtask
  task automatic commit(); step(0, 8'h00, 1, 0, 0, 0); endtask
  task automatic pop();   step(0, 8'h00, 0, 0, 0, 1); endtask
  task automatic clr();   step(0, 8'h00, 0, 0, 1, 0); endtask

  typedef struct {
    logic f; logic [7:0] d; logic c, ds, cl, r;
    logic e_rv; logic [7:0] e_rd; logic e_empty; int e_cnt; logic e_pend;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 8'hA1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1};
    tbl[1]  = '{1, 8'hB2, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1};
    tbl[2]  = '{1, 8'hC3, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1};
    tbl[3]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 3, 0};
    tbl[4]  = '{0, 8'h00, 0, 0, 0, 1, 1, 8'hA1, 0, 2, 0};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 1, 1, 8'hB2, 0, 1, 0};
    tbl[6]  = '{0, 8'h00, 0, 0, 0, 1, 1, 8'hC3, 1, 0, 0};
    tbl[7]  = '{0, 8'h00, 0, 0, 0, 1, 0, 8'hC3, 1, 0, 0};
    tbl[8]  = '{1, 8'h11, 0, 0, 0, 1, 0, 8'hC3, 1, 0, 1};
    tbl[9]  = '{0, 8'h00, 0, 1, 0, 0, 0, 8'hC3, 1, 0, 0};
    tbl[10] = '{1, 8'h22, 1, 0, 0, 0, 0, 8'hC3, 0, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 0, 0, 1, 1, 8'h22, 1, 0, 0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst rd_data", int'(rd_data), 0);
    chk("rst rd_valid", int'(rd_valid), 0);
    chk("rst fifo_empty", int'(fifo_empty), 1);
    chk("rst fifo_full", int'(fifo_full), 0);
    chk("rst byte_count", int'(byte_count), 0);
    chk("rst pend", int'(pend), 0);
    chk("rst overflow", int'(overflow), 0);
    n_rst = 1'b1;

    // Basic write/commit/pop, empty pop, discard, commit with same-cycle write.
    foreach (tbl[i]) begin
      step(tbl[i].f, tbl[i].d, tbl[i].c, tbl[i].ds, tbl[i].cl, tbl[i].r);
      chk($sformatf("tbl%0d rd_valid", i), int'(rd_valid), int'(tbl[i].e_rv));
      chk($sformatf("tbl%0d rd_data", i), int'(rd_data), int'(tbl[i].e_rd));
      chk($sformatf("tbl%0d fifo_empty", i), int'(fifo_empty), int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d byte_count", i), int'(byte_count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d pend", i), int'(pend), int'(tbl[i].e_pend));
    end

    // Uncommitted bytes are never popped; discard drops them.
    for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i));
    pop();
    chk("uncmt rd_valid", int'(rd_valid), 0);
    chk("uncmt pend", int'(pend), 1);
    step(0, 8'h00, 0, 1, 0, 0);
    chk("disc pend", int'(pend), 0);
    chk("disc byte_count", int'(byte_count), 0);

    // Fill to capacity, overflow on the 65th byte, commit acts as discard.
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    chk("full before", int'(fifo_full), 1);
    wr(8'hFF);
    chk("ovf full", int'(fifo_full), 1);
    chk("ovf flag", int'(overflow), 1);
    commit();
    chk("ovf commit cnt", int'(byte_count), 0);
    chk("ovf commit pend", int'(pend), 0);
    wr(8'h5A); commit();
    chk("idle after ovf", int'(byte_count), 1);
    chk("ovf sticky", int'(overflow), 1);
    pop();
    chk("post-ovf data", int'(rd_data), 'h5A);

    // Pointer wrap: 60 in/out, then 10 more across the wrap.
    clr();
    for (int i = 0; i < 60; i++) wr(8'(i + 1));
    commit();
    for (int i = 0; i < 60; i++) pop();
    for (int i = 0; i < 10; i++) wr(8'h80 + 8'(i));
    commit();
    chk("wrap count", int'(byte_count), 10);
    for (int i = 0; i < 10; i++) begin
      pop();
      chk("wrap data", int'(rd_data), 'h80 + i);
    end
    chk("wrap count end", int'(byte_count), 0);

    // Commit and discard together: discard wins.
    wr(8'h01); wr(8'h02); commit();
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    step(0, 8'h00, 1, 1, 0, 0);
    chk("c+d count", int'(byte_count), 2);
    chk("c+d pend", int'(pend), 0);

    // dbuff_clr with committed data and overflow set.
    clr();
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    commit();
    wr(8'hEE);
    pop();
    chk("pre-clr ovf", int'(overflow), 1);
    clr();
    chk("clr count", int'(byte_count), 0);
    chk("clr empty", int'(fifo_empty), 1);
    chk("clr ovf", int'(overflow), 0);
    chk("clr rv", int'(rd_valid), 0);
    chk("clr rd_data", int'(rd_data), 0);

    // Asynchronous reset in the middle of a packet write.
    wr(8'h31); wr(8'h32); commit(); wr(8'h33);
    fill_dbuff = 1; data = 8'h34; read_en = 1;
    #3 n_rst = 1'b0;
    #1;
    chk("arst empty", int'(fifo_empty), 1);
    chk("arst count", int'(byte_count), 0);
    chk("arst pend", int'(pend), 0);
    chk("arst rv", int'(rd_valid), 0);
    chk("arst rd_data", int'(rd_data), 0);
    model_reset();
    fill_dbuff = 0; read_en = 0;
    @(posedge clk); #1 n_rst = 1'b1;
    idle();
    pop();
    chk("arst no output", int'(rd_valid), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99) < 65, 8'($urandom),
           $urandom_range(99) < 6, $urandom_range(99) < 3,
           $urandom_range(999) < 5, $urandom_range(99) < 35);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound in case anything stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
